// File: rtl/branch_resolve_if.sv
// Execute-to-fetch branch bus between the EX stage and the branch_resolve unit.
//   master: drives the stall, the branch select, the polarity, the zero flag and both targets;
//           observes the PC, the taken flag, the flush window and the branch count.
//   slave : the branch_resolve unit.
interface branch_resolve_if #(
    parameter int unsigned PC_W  = 16,
    parameter int unsigned CNT_W = 8
);
    logic             Stall_In;
    logic [1:0]       BS_In;
    logic             PS_In;
    logic             Z_In;
    logic [PC_W-1:0]  BrAddr_In;
    logic [PC_W-1:0]  RegAddr_In;
    logic [PC_W-1:0]  PC_O;
    logic [PC_W-1:0]  PC1_O;
    logic             Taken_O;
    logic             Flush_O;
    logic [CNT_W-1:0] BrCount_O;

    modport master (
        output Stall_In, BS_In, PS_In, Z_In, BrAddr_In, RegAddr_In,
        input  PC_O, PC1_O, Taken_O, Flush_O, BrCount_O
    );

    modport slave (
        input  Stall_In, BS_In, PS_In, Z_In, BrAddr_In, RegAddr_In,
        output PC_O, PC1_O, Taken_O, Flush_O, BrCount_O
    );
endinterface

// File: rtl/branch_resolve.sv
// Program counter and branch resolution unit.
// The unit decides whether the branch in EX is taken and redirects the fetch PC.
// After a taken branch it opens a registered flush window, which squashes the
// wrong-path instructions. It also keeps a saturating count of taken branches.
// Ports:
//   CLK   : system clock
//   RESET : synchronous active-high reset
//   bus   : branch_resolve_if.slave
//           inputs : stall, branch select, polarity, zero flag, targets
//           outputs: PC_O (registered), PC1_O (combinational), Taken_O (combinational),
//                    Flush_O (registered), BrCount_O (registered)
module branch_resolve #(
    parameter int unsigned     PC_W         = 16,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int unsigned     FLUSH_CYCLES = 2,
    parameter int unsigned     CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    branch_resolve_if.slave  bus
);
    localparam int unsigned FC_W = 3;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]       state_q, state_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             taken_c;
    logic [PC_W-1:0]  target_c;

    // Taken decision. The select is ignored during reset and inside the flush window.
    always_comb begin
        taken_c = 1'b0;
        if (!RESET && state_q == RUN) begin
            case (bus.BS_In)
                2'b01:        taken_c = bus.Z_In ^ bus.PS_In;
                2'b10, 2'b11: taken_c = 1'b1;
                default:      taken_c = 1'b0;
            endcase
        end
    end

    assign target_c = (bus.BS_In == 2'b10) ? bus.RegAddr_In : bus.BrAddr_In;

    // Next state for the PC, the flush FSM and the branch counter.
    // A taken branch beats the stall, because the EX instruction is valid.
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;

        if (taken_c) begin
            pc_d = target_c;
        end else if (!bus.Stall_In) begin
            pc_d = pc_q + PC_W'(1);
        end

        if (taken_c && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            RUN: begin
                if (taken_c) begin
                    state_d = FLUSH;
                    fc_d    = FC_LOAD;
                end
            end
            FLUSH: begin
                if (bus.Stall_In) begin
                    fc_d = fc_q;
                end else if (fc_q == '0) begin
                    state_d = RUN;
                end else begin
                    fc_d = fc_q - FC_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RUN;
            fc_q    <= '0;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.PC_O      = pc_q;
    assign bus.PC1_O     = pc_q + PC_W'(1);
    assign bus.Taken_O   = taken_c;
    assign bus.Flush_O   = (state_q == FLUSH);
    assign bus.BrCount_O = cnt_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve.
// It applies a directed vector table, then hand-written corner sequences and random
// traffic. For these it uses a behavioural reference model.
module tb_branch_resolve;
    localparam int unsigned PC_W         = 16;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam logic [15:0] RESET_PC     = 16'h0040;
    localparam int          NV           = 29;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    branch_resolve_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    branch_resolve #(
        .PC_W(PC_W), .RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic [1:0]  bs;
        logic        ps;
        logic        z;
        logic [15:0] br;
        logic [15:0] rg;
        logic        e_taken;
        logic [15:0] e_pc;
        logic        e_fl;
        logic [7:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic        fl;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[NV];
    int   total = 0;
    int   bad   = 0;

    // reference model state
    logic [15:0] m_pc;
    int          m_left;
    int          m_cnt;
    bit          m_known = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(logic rst, logic stall, logic [1:0] bs, logic ps, logic z,
                                logic [15:0] br, logic [15:0] rg, logic et,
                                logic [15:0] epc, logic efl, logic [7:0] ecnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.bs = bs; v.ps = ps; v.z = z;
        v.br = br; v.rg = rg; v.e_taken = et; v.e_pc = epc; v.e_fl = efl; v.e_cnt = ecnt;
        return v;
    endfunction

    // One cycle: drive at negedge, check the combinational outputs, queue the registered
    // expectations, and compare them after the rising edge.
    task automatic apply(input vec_t v, input bit pc1_valid, input logic [15:0] pc1_exp);
        exp_t e;
        @(negedge CLK);
        RESET          = v.rst;
        bus.Stall_In   = v.stall;
        bus.BS_In      = v.bs;
        bus.PS_In      = v.ps;
        bus.Z_In       = v.z;
        bus.BrAddr_In  = v.br;
        bus.RegAddr_In = v.rg;
        #1;
        chk("taken", 32'(bus.Taken_O), 32'(v.e_taken));
        if (pc1_valid) chk("pc1", 32'(bus.PC1_O), 32'(pc1_exp));
        exp_q.push_back('{pc: v.e_pc, fl: v.e_fl, cnt: v.e_cnt});
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("pc", 32'(bus.PC_O), 32'(e.pc));
            chk("flush", 32'(bus.Flush_O), 32'(e.fl));
            chk("count", 32'(bus.BrCount_O), 32'(e.cnt));
        end
    endtask

    // The model tracks how many flush cycles remain, not the FSM encoding.
    task automatic mstep(input logic rst, input logic stall, input logic [1:0] bs,
                         input logic ps, input logic z, input logic [15:0] br,
                         input logic [15:0] rg);
        bit          in_fl;
        bit          tk;
        logic [15:0] npc;
        logic [15:0] p1;
        int          nleft;
        int          ncnt;
        in_fl = (m_left > 0);
        tk    = !rst && !in_fl && (bs == 2'b11 || bs == 2'b10 || (bs == 2'b01 && z != ps));
        if (rst) begin
            npc = RESET_PC; nleft = 0; ncnt = 0;
        end else begin
            npc   = tk ? ((bs == 2'b10) ? rg : br) : (stall ? m_pc : m_pc + 16'd1);
            nleft = tk ? int'(FLUSH_CYCLES) : ((in_fl && !stall) ? m_left - 1 : m_left);
            ncnt  = (tk && m_cnt < 255) ? m_cnt + 1 : m_cnt;
        end
        p1 = m_pc + 16'd1;
        apply(mk(rst, stall, bs, ps, z, br, rg, tk, npc, nleft > 0, 8'(ncnt)), m_known, p1);
        m_pc = npc; m_left = nleft; m_cnt = ncnt;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] p1;
        RESET = 1'b1;
        bus.Stall_In = 1'b0; bus.BS_In = 2'b00; bus.PS_In = 1'b0; bus.Z_In = 1'b0;
        bus.BrAddr_In = '0; bus.RegAddr_In = '0;

        // Directed vectors. The first four rows cover reset held for 3 cycles, then release.
        tbl[0]  = mk(1,0,2'b11,0,0,16'h1234,16'h0000, 0,16'h0040,0,8'd0);
        tbl[1]  = mk(1,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h0040,0,8'd0);
        tbl[2]  = mk(1,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h0040,0,8'd0);
        tbl[3]  = mk(0,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h0041,0,8'd0);
        tbl[4]  = mk(0,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h0042,0,8'd0);
        tbl[5]  = mk(0,0,2'b11,0,0,16'h000E,16'h0000, 1,16'h000E,1,8'd1);
        tbl[6]  = mk(0,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h000F,1,8'd1);
        tbl[7]  = mk(0,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h0010,0,8'd1);
        tbl[8]  = mk(0,0,2'b01,0,1,16'h1234,16'h0000, 1,16'h1234,1,8'd2);
        tbl[9]  = mk(0,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h1235,1,8'd2);
        tbl[10] = mk(0,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h1236,0,8'd2);
        tbl[11] = mk(0,0,2'b11,0,0,16'h000E,16'h0000, 1,16'h000E,1,8'd3);
        tbl[12] = mk(0,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h000F,1,8'd3);
        tbl[13] = mk(0,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h0010,0,8'd3);
        tbl[14] = mk(0,0,2'b01,0,0,16'h1234,16'h0000, 0,16'h0011,0,8'd3);
        tbl[15] = mk(0,0,2'b01,1,0,16'h2000,16'h0000, 1,16'h2000,1,8'd4);
        tbl[16] = mk(0,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h2001,1,8'd4);
        tbl[17] = mk(0,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h2002,0,8'd4);
        tbl[18] = mk(0,0,2'b01,1,1,16'h3000,16'h0000, 0,16'h2003,0,8'd4);
        tbl[19] = mk(0,1,2'b10,0,0,16'h1111,16'hFFFF, 1,16'hFFFF,1,8'd5);
        tbl[20] = mk(0,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h0000,1,8'd5);
        tbl[21] = mk(0,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h0001,0,8'd5);
        tbl[22] = mk(0,0,2'b11,0,0,16'h0100,16'h0000, 1,16'h0100,1,8'd6);
        tbl[23] = mk(0,0,2'b11,0,0,16'h0777,16'h0000, 0,16'h0101,1,8'd6);
        tbl[24] = mk(0,0,2'b10,0,0,16'h0999,16'h0555, 0,16'h0102,0,8'd6);
        tbl[25] = mk(0,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h0103,0,8'd6);
        tbl[26] = mk(0,1,2'b00,0,0,16'h0000,16'h0000, 0,16'h0103,0,8'd6);
        tbl[27] = mk(0,0,2'b00,0,0,16'h0000,16'h0000, 0,16'h0104,0,8'd6);
        tbl[28] = mk(0,0,2'b00,0,1,16'h0000,16'h0000, 0,16'h0105,0,8'd6);

        for (int i = 0; i < NV; i++) begin
            p1 = (i > 0) ? tbl[i-1].e_pc + 16'd1 : 16'h0000;
            apply(tbl[i], i > 0, p1);
        end

        m_pc = tbl[NV-1].e_pc; m_left = 0; m_cnt = int'(tbl[NV-1].e_cnt); m_known = 1'b1;

        // Stall in the cycle after a taken branch stretches the flush window by one.
        // A branch in the first RUN cycle after the window must be accepted.
        mstep(0,0,2'b11,0,0,16'h0300,16'h0000);
        mstep(0,1,2'b00,0,0,16'h0000,16'h0000);
        mstep(0,0,2'b11,0,0,16'h0AAA,16'h0000);
        mstep(0,0,2'b00,0,0,16'h0000,16'h0000);
        mstep(0,0,2'b11,0,0,16'h0400,16'h0000);
        chk("redirect_after_stall", 32'(bus.PC_O), 32'h0400);
        mstep(0,0,2'b00,0,0,16'h0000,16'h0000);
        mstep(0,0,2'b00,0,0,16'h0000,16'h0000);

        // Reset in the middle of a flush window leaves no residual flush.
        mstep(0,0,2'b11,0,0,16'h0500,16'h0000);
        mstep(1,0,2'b11,0,0,16'h0600,16'h0000);
        chk("rst_mid_flush_pc", 32'(bus.PC_O), 32'(RESET_PC));
        chk("rst_mid_flush_fl", 32'(bus.Flush_O), 32'd0);
        mstep(0,0,2'b00,0,0,16'h0000,16'h0000);

        // The counter saturates: 260 branches, spaced FLUSH_CYCLES+1 cycles apart.
        for (int n = 0; n < 260; n++) begin
            mstep(0,0,2'b11,0,0,16'($urandom),16'h0000);
            for (int k = 0; k < int'(FLUSH_CYCLES); k++)
                mstep(0,0,2'b00,0,0,16'h0000,16'h0000);
        end
        chk("count_saturated", 32'(bus.BrCount_O), 32'd255);

        // Random traffic with occasional reset.
        for (int n = 0; n < 200; n++) begin
            mstep($urandom_range(0,31) == 0, $urandom_range(0,3) == 0, 2'($urandom_range(0,3)),
                  1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                  16'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Program-counter and branch-resolution unit for the pipelined MCU. It consumes the execute-stage branch select, the polarity bit and the zero flag, and decides taken/not-taken. It redirects the fetch PC and drives a registered flush window that the decode-side nullify logic uses to squash wrong-path instructions. It also keeps a saturating count of taken branches for debug.

## Interface
- PC_W, 16, width of program counter and branch targets
- RESET_PC, 0, PC value loaded on reset
- FLUSH_CYCLES, 2, number of cycles Flush_O stays high after a taken branch (legal range 1..7)
- CNT_W, 8, width of taken-branch counter
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- Stall_In  input  1  hazard stall: hold PC and flush counter
- BS_In  input  2  branch select from EX: 00 none, 01 conditional, 10 jump register, 11 branch always
- PS_In  input  1  conditional polarity: 0 = take if Z_In=1, 1 = take if Z_In=0
- Z_In  input  1  zero flag of EX-stage result
- BrAddr_In  input  PC_W  PC-relative target, precomputed in EX
- RegAddr_In  input  PC_W  register-indirect target
- PC_O  output  PC_W  registered fetch address
- PC1_O  output  PC_W  PC_O+1 mod 2^PC_W, combinational, used for link writes
- Taken_O  output  1  combinational: branch in EX is taken this cycle
- Flush_O  output  1  registered: squash window active
- BrCount_O  output  CNT_W  saturating count of taken branches

## Operation
- States: RUN, FLUSH. A 3-bit down-counter fc runs in FLUSH.
- Taken condition (RUN only): BS_In=11, or BS_In=10, or (BS_In=01 and Z_In xor PS_In). BS_In=00 is never taken.
- Target: BS_In=10 selects RegAddr_In. BS_In=01 and BS_In=11 select BrAddr_In.
- In FLUSH, BS_In, PS_In and Z_In are ignored and Taken_O=0, because those instructions are wrong-path.
- PC next-state, in priority order:
  1. RESET: PC_O=RESET_PC.
  2. Taken_O: PC_O=target. This overrides Stall_In, because the EX instruction is valid.
  3. Stall_In: hold.
  4. Otherwise: PC_O=PC_O+1, wrapping 2^PC_W-1 to 0.
- FSM:
  - RUN to FLUSH on Taken_O, loading fc=FLUSH_CYCLES-1.
  - FLUSH with Stall_In: hold fc and stay in FLUSH.
  - FLUSH with fc=0: go to RUN.
  - FLUSH otherwise: fc=fc-1.
- Flush_O = (state==FLUSH).
- BrCount_O increments on every Taken_O cycle and saturates at 2^CNT_W-1. It is never decremented except by reset.
- Reset values:
  - PC_O=RESET_PC
  - Flush_O=0, state RUN, fc=0
  - BrCount_O=0
  - Taken_O=0 (state is RUN and BS_In is ignored during RESET)
- Reset mid-FLUSH: state goes to RUN on the next edge, with no residual flush.

## Timing
- Taken_O is combinational from BS_In, PS_In and Z_In in the same cycle T.
- PC_O shows the target at T+1.
- Flush_O is high for exactly FLUSH_CYCLES unstalled cycles, T+1 through T+FLUSH_CYCLES. Each stalled cycle extends the window by one.
- First non-ignored BS_In is sampled at T+FLUSH_CYCLES+1.
- Not-taken conditional: no redirect, no flush, PC increments normally.
- Back-to-back branches: a branch presented during FLUSH is dropped. It must not redirect, and it must not count.
- PC1_O tracks PC_O in the same cycle, with wrap.

## Test plan
- Reset with RESET_PC=0x0040, hold RESET for 3 cycles, then release with BS_In=00 -> PC_O sequence 0x0040, 0x0041, 0x0042; Flush_O=0; BrCount_O=0.
- Conditional branch BS_In=01, PS_In=0, Z_In=1, BrAddr_In=0x1234 at PC_O=0x0010 -> Taken_O=1 same cycle; next cycle PC_O=0x1234; Flush_O high for 2 cycles; BrCount_O=1. Repeat with Z_In=0 -> no redirect, PC_O=0x0011.
- Jump register BS_In=10, RegAddr_In=0xFFFF, with Stall_In=1 in the same cycle -> PC_O=0xFFFF next cycle (branch beats stall); then unstalled -> PC_O=0x0000 and PC1_O=0x0001 (wrap).
- BS_In=11 at T, then BS_In=11 with BrAddr_In=0x0777 at T+1 -> second branch ignored; Taken_O=0 at T+1; PC increments from first target; BrCount_O=1.
- Stall_In=1 at T+1 after a taken branch -> Flush_O stays high through T+3; state returns to RUN at T+4. Separately, assert RESET at T+1 -> Flush_O=0 and PC_O=RESET_PC at T+2.
- CNT_W=8: 260 taken BS_In=11 branches spaced FLUSH_CYCLES+1 apart -> BrCount_O saturates at 255.
